sram_responder: RTL

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder.sv | 119 +++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// Dual-port 32-bit word store with independent inst/data ports, 1-cycle registered reads,
// byte-lane writes and out-of-range tracking. On same-word write collisions the data port wins per lane.
module sram_responder #(
  parameter int          AW   = 12,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] oor_cnt,
  output logic [31:0] oor_addr
);

  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic          oor;
    logic [AW-1:0] idx;
  } dec_t;

  logic [31:0] mem [DEPTH];

  req_t ireq, dreq;
  dec_t idec, ddec;

  assign ireq = '{en: inst_sram_en, wen: inst_sram_wen, addr: inst_sram_addr, wdata: inst_sram_wdata};
  assign dreq = '{en: data_sram_en, wen: data_sram_wen, addr: data_sram_addr, wdata: data_sram_wdata};

  function automatic dec_t decode(input req_t r);
    dec_t d;
    logic in_rng;
    in_rng = (r.addr[31:AW+2] == BASE[31:AW+2]);
    d.idx  = r.addr[AW+1:2];
    d.rd   = r.en && in_rng && (r.wen == 4'b0000);
    d.wr   = r.en && in_rng && (r.wen != 4'b0000);
    d.oor  = r.en && !in_rng;
    return d;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] wen,
                                        input logic [31:0] wd);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++)
      if (wen[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  assign idec = decode(ireq);
  assign ddec = decode(dreq);

  // Byte offset bits never select anything; word granularity only.
  logic unused_ok;
  assign unused_ok = ^{inst_sram_addr[1:0], data_sram_addr[1:0]};

  logic        coll;
  logic [31:0] i_merge, d_merge, i_final;

  // On a write/write collision the data port merges on top of the inst result, so one word
  // carries both ports' lanes with data winning overlaps.
  assign coll    = idec.wr && ddec.wr && (idec.idx == ddec.idx);
  assign i_merge = merge(mem[idec.idx], ireq.wen, ireq.wdata);
  assign d_merge = merge(coll ? i_merge : mem[ddec.idx], dreq.wen, dreq.wdata);
  assign i_final = coll ? d_merge : i_merge;

  logic [16:0] cnt_sum;
  logic [15:0] cnt_nxt;

  assign cnt_sum = {1'b0, oor_cnt} + 17'(idec.oor) + 17'(ddec.oor);
  assign cnt_nxt = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  // Storage is never cleared; writes are simply gated while reset is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (idec.wr) mem[idec.idx] <= i_final;
      if (ddec.wr) mem[ddec.idx] <= d_merge;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_sram_rdata <= '0;
      data_sram_rdata <= '0;
      oor_cnt         <= '0;
      oor_addr        <= '0;
    end else begin
      if (idec.wr)       inst_sram_rdata <= i_final;
      else if (idec.rd)  inst_sram_rdata <= mem[idec.idx];
      else if (idec.oor) inst_sram_rdata <= '0;

      if (ddec.wr)       data_sram_rdata <= d_merge;
      else if (ddec.rd)  data_sram_rdata <= mem[ddec.idx];
      else if (ddec.oor) data_sram_rdata <= '0;

      oor_cnt <= cnt_nxt;
      if (ddec.oor)      oor_addr <= dreq.addr;
      else if (idec.oor) oor_addr <= ireq.addr;
    end
  end

endmodule
